// File: rtl/psr_write_arbiter_if.sv
// rtl/psr_write_arbiter_if.sv - request/grant bundle between the execution paths and the status-register arbiter
interface psr_write_arbiter_if;
  logic       req0;
  logic       req1;
  logic [1:0] st0;
  logic [1:0] st1;
  logic       rdy0;
  logic       rdy1;
  logic       lock0;
  logic       lock1;
  logic [4:0] status;
  logic [4:0] newstatus;
  logic       gnt0;
  logic       gnt1;
  logic [1:0] owner;

  modport master (
    output req0, req1, st0, st1, rdy0, rdy1, lock0, lock1, status,
    input  newstatus, gnt0, gnt1, owner
  );

  modport slave (
    input  req0, req1, st0, st1, rdy0, rdy1, lock0, lock1, status,
    output newstatus, gnt0, gnt1, owner
  );
endinterface

// File: rtl/psr_write_arbiter.sv
// rtl/psr_write_arbiter.sv - round-robin status-register write arbiter with bounded ownership lock
module psr_write_arbiter #(
  parameter int LOCK_MAX = 8
) (
  input logic                clk,
  input logic                preset,
  psr_write_arbiter_if.slave bus
);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [LW-1:0] LCNT_MAX = LW'(LOCK_MAX);
  localparam logic [LW-1:0] LCNT_ONE = LW'(1);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  logic [1:0]    state;
  logic          ptr;
  logic [LW-1:0] lcnt;
  logic          g0;
  logic          g1;

  // Grants are Mealy: registered state/ptr combined with this cycle's requests.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!preset) begin
      case (state)
        IDLE: begin
          if (bus.req0 && bus.req1) begin
            g0 = !ptr;
            g1 = ptr;
          end else begin
            g0 = bus.req0;
            g1 = bus.req1;
          end
        end
        OWN0:    g0 = bus.req0;
        OWN1:    g1 = bus.req1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.newstatus = bus.status;
    if (preset)
      bus.newstatus = 5'b00000;
    else if (g0)
      bus.newstatus = {bus.rdy0, bus.st0, 2'b01};
    else if (g1)
      bus.newstatus = {bus.rdy1, bus.st1, 2'b10};
  end

  assign bus.gnt0  = g0;
  assign bus.gnt1  = g1;
  assign bus.owner = state;

  always_ff @(posedge clk) begin
    if (preset) begin
      state <= IDLE;
      ptr   <= 1'b0;
      lcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (g0) begin
            ptr <= 1'b1;
            if (bus.lock0) begin
              state <= OWN0;
              lcnt  <= LCNT_ONE;
            end
          end else if (g1) begin
            ptr <= 1'b0;
            if (bus.lock1) begin
              state <= OWN1;
              lcnt  <= LCNT_ONE;
            end
          end
        end
        OWN0: begin
          // Timeout wins over a still-asserted lock so path1 cannot starve.
          if (lcnt == LCNT_MAX) begin
            state <= IDLE;
            ptr   <= 1'b1;
            lcnt  <= '0;
          end else if (!bus.lock0) begin
            state <= IDLE;
            lcnt  <= '0;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        OWN1: begin
          if (lcnt == LCNT_MAX) begin
            state <= IDLE;
            ptr   <= 1'b0;
            lcnt  <= '0;
          end else if (!bus.lock1) begin
            state <= IDLE;
            lcnt  <= '0;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          lcnt  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_psr_write_arbiter.sv
// tb/tb_psr_write_arbiter.sv - directed-vector bench for psr_write_arbiter
module tb_psr_write_arbiter;
  logic clk = 1'b0;
  logic preset;
  int   errors = 0;
  int   checks = 0;

  psr_write_arbiter_if bus ();

  psr_write_arbiter #(.LOCK_MAX(8)) dut (
    .clk    (clk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r0, input logic l0, input logic r1, input logic l1);
    bus.req0  = r0;
    bus.lock0 = l0;
    bus.req1  = r1;
    bus.lock1 = l1;
  endtask

  task automatic expect_out(input string tag, input logic e0, input logic e1, input logic [4:0] ens);
    #2;
    check({tag, ".gnt0"}, 32'(bus.gnt0), 32'(e0));
    check({tag, ".gnt1"}, 32'(bus.gnt1), 32'(e1));
    check({tag, ".newstatus"}, 32'(bus.newstatus), 32'(ens));
  endtask

  initial begin
    preset     = 1'b1;
    bus.st0    = 2'b01;
    bus.rdy0   = 1'b1;
    bus.st1    = 2'b10;
    bus.rdy1   = 1'b0;
    bus.status = 5'b10110;
    set_req(1'b1, 1'b0, 1'b1, 1'b0);

    // Reset: no grants, zero newstatus
    expect_out("reset", 1'b0, 1'b0, 5'b00000);
    tick();
    check("reset.owner", 32'(bus.owner), 32'd0);
    preset = 1'b0;

    // Alternation, starting with path0
    expect_out("alt0", 1'b1, 1'b0, 5'b10101);
    tick();
    expect_out("alt1", 1'b0, 1'b1, 5'b01010);
    tick();
    expect_out("alt2", 1'b1, 1'b0, 5'b10101);
    tick();
    expect_out("alt3", 1'b0, 1'b1, 5'b01010);
    tick();

    // Idle hold
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    bus.status = 5'b11001;
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("idle%0d", i), 1'b0, 1'b0, 5'b11001);
      tick();
    end

    // Lock by path0; ptr is 0 after the alternation
    set_req(1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("lock.grant", 1'b1, 1'b0, 5'b10101);
    tick();
    bus.status = 5'b10101;
    set_req(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.lock0 = 1'b0;
      check($sformatf("lock.owner%0d", i), 32'(bus.owner), 32'd1);
      expect_out($sformatf("lock.held%0d", i), 1'b0, 1'b0, 5'b10101);
      tick();
    end
    check("lock.released", 32'(bus.owner), 32'd0);
    expect_out("lock.gnt1", 1'b0, 1'b1, 5'b01010);
    tick();

    // Timeout: path1 takes the lock, path0 waits
    bus.st1    = 2'b11;
    bus.rdy1   = 1'b1;
    bus.status = 5'b01010;
    set_req(1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("to.grant", 1'b0, 1'b1, 5'b11110);
    tick();
    bus.req0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      bus.req1 = k[0];
      check($sformatf("to.owner%0d", k), 32'(bus.owner), 32'd2);
      expect_out($sformatf("to.own%0d", k), 1'b0, k[0], k[0] ? 5'b11110 : 5'b01010);
      tick();
    end
    bus.req1 = 1'b1;
    check("to.released", 32'(bus.owner), 32'd0);
    expect_out("to.after", 1'b1, 1'b0, 5'b10101);
    tick();

    // Reset mid-lock; ptr is now 1
    set_req(1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("rml.grant", 1'b0, 1'b1, 5'b11110);
    tick();
    check("rml.owner", 32'(bus.owner), 32'd2);
    preset = 1'b1;
    expect_out("rml.reset", 1'b0, 1'b0, 5'b00000);
    tick();
    check("rml.owner_after", 32'(bus.owner), 32'd0);
    preset = 1'b0;
    set_req(1'b1, 1'b0, 1'b1, 1'b0);
    expect_out("rml.ptr0", 1'b1, 1'b0, 5'b10101);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psr_write_arbiter.md
# psr_write_arbiter

Arbitrates status-register writes from the two execution paths (path0, path1) onto the single `newstatus` port of the processor status register. Each cycle it grants at most one requester, or holds the current status by feeding it back. Arbitration is round-robin, with an optional lock that lets one path own the status register for a bounded number of cycles. A lock timeout guarantees the other path cannot starve.

## Interface
- `LOCK_MAX`, 8: maximum consecutive cycles one path may hold a lock (≥1)
- `clk  in  1`  sole clock, rising edge
- `preset  in  1`  reset, synchronous, active-high
- `req0`, `req1`  in  1  write request from path0 / path1; held until granted
- `st0`, `st1`  in  2  requested status code, written to {status1,status0}
- `rdy0`, `rdy1`  in  1  requested data_ready value
- `lock0`, `lock1`  in  1  request to retain ownership after grant
- `status`  in  5  current status-register output {data_ready,status1,status0,path1,path0}
- `newstatus`  out  5  next status-register value
- `gnt0`, `gnt1`  out  1  write accepted this cycle (combinational, one-hot or zero)
- `owner`  out  2  registered ownership: 00 none, 01 path0, 10 path1

## Operation
- State machine:
  - IDLE: no lock owner.
  - OWN0: path0 owns the register.
  - OWN1: path1 owns the register.
- Round-robin pointer `ptr`, 1 bit: the path favoured on the next conflict.
- Lock counter `lcnt`, width clog2(LOCK_MAX+1).
- IDLE:
  - Exactly one req: grant it.
  - Both req: grant `ptr` side.
  - After any grant, `ptr` points to the other path.
  - Granted path with lock=1: go to OWN of that path, `lcnt`=1.
- OWN_x:
  - Only x may be granted; the other path's req stalls (gnt=0).
  - req_x is granted regardless of `ptr`.
  - lock_x=0: go to IDLE. A req_x in that same cycle is still granted.
  - lock_x=1 and `lcnt`<LOCK_MAX: stay in OWN_x, `lcnt`+1.
  - `lcnt`==LOCK_MAX: forced release to IDLE, `ptr` set to the other path.
  - The forced-release cycle still grants req_x if it is present.
- newstatus:
  - gnt0: {rdy0, st0, 2'b01}.
  - gnt1: {rdy1, st1, 2'b10}.
  - No grant: `status`, so the held value is unchanged.
- path bits are one-hot and identify the last writer. They are never 11.

## Timing
- Grant is same-cycle (Mealy):
  - gnt is a function of the req inputs and the registered state/`ptr`.
  - The write lands in the status register at the next rising edge.
  - `status` reflects it one cycle after gnt.
- Requester rules:
  - Keep req, st, rdy and lock stable until the edge at which gnt=1.
  - Drop req, or present a new request, in the following cycle.
- While preset=1:
  - gnt0=gnt1=0, newstatus=5'b00000.
  - State←IDLE, `ptr`←0 (path0 favoured), `lcnt`←0, `owner`←00.
- preset mid-lock: ownership is abandoned immediately. No grant is issued in the reset cycle.
- LOCK_MAX=1: a lock never survives more than one owned cycle after the locking grant.
- `owner` changes only at clock edges and reflects the state register.

## Test plan
- Reset:
  - Stimulus: preset=1 with req0=req1=1, status=5'b10110.
  - Required: gnt0=gnt1=0, newstatus=00000.
  - After release, first conflict goes to path0.
- Alternation:
  - Stimulus: req0 and req1 held high for 4 cycles with no lock; st0=2'b01, rdy0=1; st1=2'b10, rdy1=0.
  - Required grants: path0, path1, path0, path1.
  - Required newstatus: 10101, 01010, 10101, 01010.
- Idle hold:
  - Stimulus: no req for 3 cycles, status=5'b11001.
  - Required: newstatus=11001 every cycle, gnt0=gnt1=0.
- Lock:
  - Stimulus: req0 with lock0=1 granted, then req1 asserted; lock0 dropped 3 cycles later.
  - Required: gnt1=0 and owner=01 while locked.
  - gnt1 is asserted in the first cycle after owner returns to 00.
- Timeout:
  - Stimulus: LOCK_MAX=8, lock1 held high with req1 pulsing, req0 held high.
  - Required: forced release after 8 owned cycles, owner=00.
  - The next cycle grants path0.
- Reset mid-lock:
  - Stimulus: preset while owner=10.
  - Required: next cycle owner=00, newstatus=00000 during preset.
